// File: rtl/sync_arb_pkg.sv
// Shared types and parameter defaults for the synchronizing round-robin arbiter.
package sync_arb_pkg;

    localparam int DEFAULT_NUM_REQ        = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/req_sync.sv
// Two-flop synchronizer bringing one asynchronous request level into the clk domain.
module req_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for asynchronous requesters with per-grant timeout and
// a mandatory release/idle gap between grants.
module sync_req_arbiter
    import sync_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         async_req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [NUM_REQ-1:0] sreq;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
        req_sync u_req_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (async_req[g]),
            .sync_out (sreq[g])
        );
    end

    arb_state_t         state, state_next;
    logic [ID_W-1:0]    owner, owner_next;
    logic [ID_W-1:0]    ptr, ptr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [ID_W-1:0]    grant_id_next;
    logic               busy_next;
    logic               timeout_next;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    cand;
    logic               timed_out;
    logic               owner_req;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        ptr_next      = ptr;
        cnt_next      = cnt;
        grant_next    = grant;
        grant_id_next = grant_id;
        busy_next     = busy;
        timeout_next  = 1'b0;
        found         = 1'b0;
        win           = '0;
        cand          = '0;
        timed_out     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        owner_req     = sreq[owner];

        // Search starts at ptr and wraps, so the first hit is the round-robin winner.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && sreq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state)
            IDLE: begin
                grant_next    = '0;
                grant_id_next = '0;
                busy_next     = 1'b0;
                cnt_next      = '0;
                if (found) begin
                    state_next    = GRANT;
                    owner_next    = win;
                    grant_next    = NUM_REQ'(1) << win;
                    grant_id_next = win;
                    busy_next     = 1'b1;
                end
            end
            GRANT: begin
                if (done || !owner_req || timed_out) begin
                    state_next    = RELEASE;
                    grant_next    = '0;
                    grant_id_next = '0;
                    busy_next     = 1'b0;
                    // done and a dropped request both count as a normal finish.
                    timeout_next  = timed_out && !done && owner_req;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_next = IDLE;
                cnt_next   = '0;
                ptr_next   = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
            end
            default: begin
                state_next    = IDLE;
                grant_next    = '0;
                grant_id_next = '0;
                busy_next     = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            ptr         <= ptr_next;
            cnt         <= cnt_next;
            grant       <= grant_next;
            grant_id    <= grant_id_next;
            busy        <= busy_next;
            timeout_err <= timeout_next;
        end
    end

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed self-checking bench for sync_req_arbiter; inputs driven and outputs
// sampled on the falling edge.
module tb_sync_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    sync_req_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .async_req   (async_req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        async_req = 4'b0000;
        done      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advance until a grant is visible, giving up after a fixed budget.
    task automatic wait_grant(input string tag, output int waited);
        waited = 0;
        while (grant == 4'b0000 && waited < 12) begin
            tick();
            waited++;
        end
        if (grant == 4'b0000) check({tag, "_wait_expired"}, 32'(grant), 32'hF);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int waited;
    int hi;

    initial begin
        // Reset state and done ignored while idle
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("idle_done_busy", 32'(busy), 32'h0);

        // Single request: three-cycle latency, hold, then done
        async_req = 4'b0100;
        tick();
        check("single_lat_c1", 32'(grant), 32'h0);
        tick();
        check("single_lat_c2", 32'(grant), 32'h0);
        tick();
        check("single_grant", 32'(grant), 32'h4);
        check("single_grant_id", 32'(grant_id), 32'h2);
        check("single_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_hold", 32'(grant), 32'h4);
        end
        tick();
        done = 1'b1;
        check("single_done_cycle", 32'(grant), 32'h4);
        tick();
        done = 1'b0;
        check("single_release_grant", 32'(grant), 32'h0);
        check("single_release_busy", 32'(busy), 32'h0);
        check("single_release_id", 32'(grant_id), 32'h0);
        check("single_release_to", 32'(timeout_err), 32'h0);

        // Round-robin over four held requests
        do_reset();
        async_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant("rr", waited);
            if (n > 0) check("rr_gap", 32'(waited), 32'd2);
            check("rr_grant_id", 32'(grant_id), 32'(order[n]));
            check("rr_grant", 32'(grant), 32'(4'b0001 << order[n]));
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end

        // Timeout: grant held exactly 16 cycles, one error pulse, regrant after 2
        do_reset();
        async_req = 4'b0001;
        wait_grant("to", waited);
        hi = 0;
        while (grant != 4'b0000 && hi < 40) begin
            if (timeout_err) check("to_early_pulse", 32'(timeout_err), 32'h0);
            hi++;
            tick();
        end
        check("to_grant_len", 32'(hi), 32'd16);
        check("to_pulse", 32'(timeout_err), 32'h1);
        tick();
        check("to_pulse_end", 32'(timeout_err), 32'h0);
        check("to_idle_gap", 32'(grant), 32'h0);
        tick();
        check("to_regrant", 32'(grant), 32'h1);

        // done in the same cycle as cnt==15: done wins
        for (int i = 0; i < 15; i++) tick();
        check("sim_last_cycle", 32'(grant), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("sim_release_grant", 32'(grant), 32'h0);
        check("sim_release_to", 32'(timeout_err), 32'h0);
        tick();
        check("sim_idle_to", 32'(timeout_err), 32'h0);

        // Request drop on requester 3, then ptr must have wrapped to 0
        do_reset();
        async_req = 4'b1000;
        wait_grant("drop", waited);
        check("drop_grant_id", 32'(grant_id), 32'h3);
        tick();
        async_req = 4'b0000;
        tick();
        check("drop_c1", 32'(grant), 32'h8);
        tick();
        check("drop_c2", 32'(grant), 32'h8);
        tick();
        check("drop_c3", 32'(grant), 32'h0);
        async_req = 4'b1001;
        wait_grant("drop_next", waited);
        check("drop_ptr_wrap", 32'(grant_id), 32'h0);

        // Reset in the middle of a grant
        do_reset();
        async_req = 4'b0010;
        wait_grant("mid", waited);
        check("mid_grant_id", 32'(grant_id), 32'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_id", 32'(grant_id), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_to", 32'(timeout_err), 32'h0);
        tick();
        check("mid_after_c1", 32'(grant), 32'h0);
        tick();
        check("mid_after_c2", 32'(grant), 32'h0);
        wait_grant("mid_after", waited);
        check("mid_regrant", 32'(grant), 32'h2);
        check("mid_regrant_id", 32'(grant_id), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
